// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice scheduler. Key events arrive over a valid/ready port.
// Each note-on is assigned to a free voice, and each note-off releases the
// voice holding that key. A released voice stays busy until its envelope fall
// has finished. Only then can it be reused.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   key_valid    event present
//   key_ready    event accepted when key_valid & key_ready
//   key_on       1 = note-on, 0 = note-off
//   key_code     key of the event
//   fall_time    envelope fall length in cycles, sampled at note-off / all_off
//   all_off      panic: release every held voice
//   voice_press  per-voice press line to the envelope bank
//   voice_key    per-voice key code, voice i at [i*KEY_W +: KEY_W]
//   voice_busy   voice is HELD or RELEASING
//   evt_alloc    one-cycle pulse: note-on allocated to evt_voice
//   evt_voice    voice index that goes with the event pulses / released voice
//   evt_drop     one-cycle pulse: note-on dropped
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter  int NUM_VOICES  = 4,
    parameter  int KEY_W       = 7,
    parameter  int RELEASE_PAD = 3,
    localparam int VIDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic                        key_on,
    input  logic [KEY_W-1:0]            key_code,
    input  logic [11:0]                 fall_time,
    input  logic                        all_off,
    output logic [NUM_VOICES-1:0]       voice_press,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_busy,
    output logic                        evt_alloc,
    output logic [VIDX_W-1:0]           evt_voice,
    output logic                        evt_drop
);

    typedef enum logic {
        IDLE,
        EXEC
    } fsm_t;

    typedef enum logic [1:0] {
        FREE,
        HELD,
        RELEASING
    } vstate_t;

    localparam logic [12:0] PAD13 = 13'(RELEASE_PAD);

    fsm_t              state;
    vstate_t           vstate  [NUM_VOICES];
    logic [12:0]       rel_cnt [NUM_VOICES];
    logic [KEY_W-1:0]  vkey    [NUM_VOICES];

    logic              cap_on;
    logic [KEY_W-1:0]  cap_code;
    logic [11:0]       cap_fall;

    logic              free_any;
    logic [VIDX_W-1:0] free_idx;
    logic              held_any;
    logic [VIDX_W-1:0] held_idx;
    logic              exec;
    logic              do_alloc;
    logic              do_drop;
    logic              do_off;
    logic [12:0]       load_now;
    logic [12:0]       load_cap;

    // Decisions are based on the registered voice state, so a voice that
    // frees on the EXEC->IDLE edge is not a candidate for that event. The
    // loops scan downward so that the lowest matching index wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        held_any = 1'b0;
        held_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (vstate[i] == FREE) begin
                free_any = 1'b1;
                free_idx = VIDX_W'(i);
            end
            if (vstate[i] == HELD && vkey[i] == cap_code) begin
                held_any = 1'b1;
                held_idx = VIDX_W'(i);
            end
        end
        exec     = (state == EXEC);
        // all_off takes priority: it drops a pending note-on and cancels a
        // pending note-off, because it releases every held voice anyway.
        do_alloc = exec && cap_on && !all_off && !held_any && free_any;
        do_drop  = exec && cap_on && (all_off || (!held_any && !free_any));
        do_off   = exec && !cap_on && !all_off && held_any;
        load_now = {1'b0, fall_time} + PAD13;
        load_cap = {1'b0, cap_fall} + PAD13;
    end

    // Control FSM. It accepts an event in IDLE and applies it in EXEC.
    // key_ready is registered, so it stays low in the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_ready <= 1'b0;
            cap_on    <= 1'b0;
            cap_code  <= '0;
            cap_fall  <= '0;
            evt_alloc <= 1'b0;
            evt_drop  <= 1'b0;
            evt_voice <= '0;
        end else begin
            evt_alloc <= do_alloc;
            evt_drop  <= do_drop;
            if (do_alloc) begin
                evt_voice <= free_idx;
            end else if (do_off) begin
                evt_voice <= held_idx;
            end
            case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        cap_on    <= key_on;
                        cap_code  <= key_code;
                        cap_fall  <= fall_time;
                        state     <= EXEC;
                        key_ready <= 1'b0;
                    end else begin
                        key_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    key_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-voice state and release counters. A releasing voice frees on the
    // edge where its count is 1, so a load of N keeps it busy for N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i]  <= FREE;
                rel_cnt[i] <= '0;
                vkey[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                case (vstate[i])
                    FREE: begin
                        if (do_alloc && free_idx == VIDX_W'(i)) begin
                            vstate[i] <= HELD;
                            vkey[i]   <= cap_code;
                        end
                    end
                    HELD: begin
                        if (all_off) begin
                            vstate[i]  <= RELEASING;
                            rel_cnt[i] <= load_now;
                        end else if (do_off && held_idx == VIDX_W'(i)) begin
                            vstate[i]  <= RELEASING;
                            rel_cnt[i] <= load_cap;
                        end
                    end
                    RELEASING: begin
                        rel_cnt[i] <= rel_cnt[i] - 13'd1;
                        if (rel_cnt[i] <= 13'd1) begin
                            vstate[i] <= FREE;
                        end
                    end
                    default: begin
                        vstate[i] <= FREE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        voice_press = '0;
        voice_busy  = '0;
        voice_key   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_press[i]              = (vstate[i] == HELD);
            voice_busy[i]               = (vstate[i] != FREE);
            voice_key[i*KEY_W +: KEY_W] = vkey[i];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed bench for voice_allocator. It runs a table of key events with
// hand-computed results, then hand-written sequences for release timing,
// reuse while a voice is releasing, and reset in the middle of an event.
// ---------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int KW = 7;
    localparam int VW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_valid;
    logic             key_ready;
    logic             key_on;
    logic [KW-1:0]    key_code;
    logic [11:0]      fall_time;
    logic             all_off;
    logic [NV-1:0]    voice_press;
    logic [NV*KW-1:0] voice_key;
    logic [NV-1:0]    voice_busy;
    logic             evt_alloc;
    logic [VW-1:0]    evt_voice;
    logic             evt_drop;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    voice_allocator #(
        .NUM_VOICES (NV),
        .KEY_W      (KW),
        .RELEASE_PAD(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_on     (key_on),
        .key_code   (key_code),
        .fall_time  (fall_time),
        .all_off    (all_off),
        .voice_press(voice_press),
        .voice_key  (voice_key),
        .voice_busy (voice_busy),
        .evt_alloc  (evt_alloc),
        .evt_voice  (evt_voice),
        .evt_drop   (evt_drop)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to measure release lengths.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rst;
        bit          on;
        logic [6:0]  code;
        logic [11:0] fall;
        bit          aoff;
        bit          ealloc;
        bit          edrop;
        bit          chkv;
        logic [1:0]  evoice;
        logic [3:0]  epress;
        logic [3:0]  ebusy;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reset, then leave the bench at a negedge with key_ready already high.
    task automatic doReset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        all_off   = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", key_ready, 0);
        checkOutput("reset_press", voice_press, 0);
        checkOutput("reset_busy", voice_busy, 0);
        checkOutput("reset_evt", {evt_alloc, evt_drop}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Present one event and wait until its results are visible, which is the
    // negedge after the EXEC->IDLE edge. all_off can be raised during EXEC.
    task automatic applyStimulus(input bit on, input logic [6:0] code,
                                 input logic [11:0] fall, input bit aoff);
        int n = 0;
        while (!key_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", key_ready, 1);
        key_valid = 1'b1;
        key_on    = on;
        key_code  = code;
        fall_time = fall;
        @(negedge clk);
        key_valid = 1'b0;
        all_off   = aoff;
        checkOutput("ready_low_exec", key_ready, 0);
        checkOutput("no_evt_in_exec", {evt_alloc, evt_drop}, 0);
        @(negedge clk);
        all_off = 1'b0;
    endtask

    initial begin
        int t0;
        int ev;

        key_valid = 1'b0;
        key_on    = 1'b0;
        key_code  = '0;
        fall_time = '0;
        all_off   = 1'b0;
        rst_n     = 1'b1;

        //            rst on code fall aoff alloc drop chkv ev press    busy
        vecs[0]  = '{1, 1, 60, 0, 0, 1, 0, 1, 0, 4'b0001, 4'b0001};
        vecs[1]  = '{0, 1, 62, 0, 0, 1, 0, 1, 1, 4'b0011, 4'b0011};
        vecs[2]  = '{0, 1, 64, 0, 0, 1, 0, 1, 2, 4'b0111, 4'b0111};
        vecs[3]  = '{0, 1, 65, 0, 0, 1, 0, 1, 3, 4'b1111, 4'b1111};
        vecs[4]  = '{0, 1, 67, 0, 0, 0, 1, 0, 0, 4'b1111, 4'b1111};
        vecs[5]  = '{0, 1, 62, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b1111};
        vecs[6]  = '{0, 0, 62, 0, 0, 0, 0, 1, 1, 4'b1101, 4'b1111};
        vecs[7]  = '{0, 0, 99, 0, 0, 0, 0, 0, 0, 4'b1101, 4'b1111};
        vecs[8]  = '{0, 1, 70, 0, 0, 1, 0, 1, 1, 4'b1111, 4'b1111};
        vecs[9]  = '{1, 1, 60, 5, 0, 1, 0, 1, 0, 4'b0001, 4'b0001};
        vecs[10] = '{0, 1, 62, 5, 0, 1, 0, 1, 1, 4'b0011, 4'b0011};
        vecs[11] = '{0, 1, 64, 5, 0, 1, 0, 1, 2, 4'b0111, 4'b0111};
        vecs[12] = '{0, 1, 66, 5, 1, 0, 1, 0, 0, 4'b0000, 4'b0111};
        vecs[13] = '{0, 1, 68, 5, 0, 1, 0, 1, 3, 4'b1000, 4'b1111};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].on, vecs[i].code, vecs[i].fall, vecs[i].aoff);
            checkOutput($sformatf("v%0d_alloc", i), evt_alloc, vecs[i].ealloc);
            checkOutput($sformatf("v%0d_drop", i), evt_drop, vecs[i].edrop);
            checkOutput($sformatf("v%0d_press", i), voice_press, vecs[i].epress);
            checkOutput($sformatf("v%0d_busy", i), voice_busy, vecs[i].ebusy);
            if (vecs[i].chkv) begin
                checkOutput($sformatf("v%0d_voice", i), evt_voice, vecs[i].evoice);
            end
            if (vecs[i].ealloc) begin
                ev = int'(vecs[i].evoice);
                checkOutput($sformatf("v%0d_key", i), voice_key[ev*KW +: KW], vecs[i].code);
            end
        end

        // Release timing while a new note reuses the same key on another voice.
        doReset();
        applyStimulus(1, 60, 0, 0);
        checkOutput("rel_press_on", voice_press, 4'b0001);
        applyStimulus(0, 60, 10, 0);
        t0 = cyc;
        checkOutput("rel_press_off", voice_press, 4'b0000);
        checkOutput("rel_busy_off", voice_busy, 4'b0001);
        checkOutput("rel_off_voice", evt_voice, 0);
        applyStimulus(1, 60, 10, 0);
        checkOutput("reuse_alloc", evt_alloc, 1);
        checkOutput("reuse_voice", evt_voice, 1);
        checkOutput("reuse_press", voice_press, 4'b0010);
        checkOutput("reuse_busy", voice_busy, 4'b0011);
        checkOutput("reuse_key1", voice_key[KW +: KW], 60);
        while (voice_busy[0] && (cyc - t0) < 40) @(negedge clk);
        checkOutput("release_len", cyc - t0, 13);
        checkOutput("release_key_kept", voice_key[0 +: KW], 60);
        checkOutput("release_other_busy", voice_busy, 4'b0010);

        // Reset while an event is in EXEC and voices are busy.
        applyStimulus(1, 72, 0, 0);
        checkOutput("pre_rst_busy", voice_busy, 4'b0011);
        key_valid = 1'b1;
        key_on    = 1'b1;
        key_code  = 7'd80;
        @(negedge clk);
        rst_n     = 1'b0;
        key_valid = 1'b0;
        #1;
        checkOutput("midrst_press", voice_press, 0);
        checkOutput("midrst_busy", voice_busy, 0);
        checkOutput("midrst_key", voice_key, 0);
        checkOutput("midrst_evt", {evt_alloc, evt_drop}, 0);
        checkOutput("midrst_ready", key_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 50, 0, 0);
        checkOutput("postrst_alloc", evt_alloc, 1);
        checkOutput("postrst_voice", evt_voice, 0);
        checkOutput("postrst_press", voice_press, 4'b0001);
        @(negedge clk);
        checkOutput("pulse_one_cycle", evt_alloc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
